// File: rtl/sn54ls153_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sn54ls153_pkg
// Description : Shared select/strobe encodings for the registered dual 4:1
//               data selector.
// Revision    : 1.0 - initial release
// ============================================================================
package sn54ls153_pkg;

    // Select index {B,A} -> data input chosen
    localparam logic [1:0] SEL_C0 = 2'b00;
    localparam logic [1:0] SEL_C1 = 2'b01;
    localparam logic [1:0] SEL_C2 = 2'b10;
    localparam logic [1:0] SEL_C3 = 2'b11;

    // Strobe level that enables a section
    localparam logic STB_ACTIVE = 1'b0;

endpackage : sn54ls153_pkg
`default_nettype wire

// File: rtl/sn54ls153_section.sv
`default_nettype none
// ============================================================================
// Module      : ls153_section
// Description : One strobe-gated 4:1 selector section with a registered
//               output and synchronous active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module ls153_section
    import sn54ls153_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       sel,
    input  logic             g,
    input  logic [WIDTH-1:0] c0,
    input  logic [WIDTH-1:0] c1,
    input  logic [WIDTH-1:0] c2,
    input  logic [WIDTH-1:0] c3,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] w_sel_data;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] r_y;

    // 4:1 selection on the shared select index
    always_comb begin
        w_sel_data = c3;
        case (sel)
            SEL_C0:  w_sel_data = c0;
            SEL_C1:  w_sel_data = c1;
            SEL_C2:  w_sel_data = c2;
            default: w_sel_data = c3;
        endcase
    end

    // Inactive strobe forces the section low, independent of select and data
    always_comb begin
        w_next = '0;
        if (g == STB_ACTIVE) begin
            w_next = w_sel_data;
        end
    end

    // Output register; reset wins over strobe and data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y <= '0;
        end else begin
            r_y <= w_next;
        end
    end

    assign y = r_y;

endmodule : ls153_section
`default_nettype wire

// File: rtl/sn54ls153.sv
`default_nettype none
// ============================================================================
// Module      : sn54ls153
// Description : Registered dual 4-to-1 data selector. Two independent
//               sections share the {B,A} select; each has its own
//               active-low strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module sn54ls153
    import sn54ls153_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_B,
    input  logic             i_A,
    input  logic             i_1G,
    input  logic             i_2G,
    input  logic [WIDTH-1:0] i_1C0,
    input  logic [WIDTH-1:0] i_1C1,
    input  logic [WIDTH-1:0] i_1C2,
    input  logic [WIDTH-1:0] i_1C3,
    input  logic [WIDTH-1:0] i_2C0,
    input  logic [WIDTH-1:0] i_2C1,
    input  logic [WIDTH-1:0] i_2C2,
    input  logic [WIDTH-1:0] i_2C3,
    output logic [WIDTH-1:0] o_1Y,
    output logic [WIDTH-1:0] o_2Y
);

    logic [1:0] w_sel;

    assign w_sel = {i_B, i_A};

    ls153_section #(.WIDTH(WIDTH)) u_section1 (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .sel   (w_sel),
        .g     (i_1G),
        .c0    (i_1C0),
        .c1    (i_1C1),
        .c2    (i_1C2),
        .c3    (i_1C3),
        .y     (o_1Y)
    );

    ls153_section #(.WIDTH(WIDTH)) u_section2 (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .sel   (w_sel),
        .g     (i_2G),
        .c0    (i_2C0),
        .c1    (i_2C1),
        .c2    (i_2C2),
        .c3    (i_2C3),
        .y     (o_2Y)
    );

endmodule : sn54ls153
`default_nettype wire

// File: tb/tb_sn54ls153.sv
`default_nettype none
// ============================================================================
// Module      : tb_sn54ls153
// Description : Self-checking bench for the registered dual 4:1 selector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sn54ls153;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         b, a;
    logic         g1, g2;
    logic [W-1:0] c1 [4];
    logic [W-1:0] c2 [4];
    logic [W-1:0] y1, y2;

    int tests;
    int fails;

    sn54ls153 #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_B     (b),
        .i_A     (a),
        .i_1G    (g1),
        .i_2G    (g2),
        .i_1C0   (c1[0]),
        .i_1C1   (c1[1]),
        .i_1C2   (c1[2]),
        .i_1C3   (c1[3]),
        .i_2C0   (c2[0]),
        .i_2C1   (c2[1]),
        .i_2C2   (c2[2]),
        .i_2C3   (c2[3]),
        .o_1Y    (y1),
        .o_2Y    (y2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector: inputs as {C0,C1,C2,C3} bit patterns, expected outputs
    typedef struct {
        logic       rst_n;
        logic [1:0] sel;
        logic       g1;
        logic       g2;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       e1;
        logic       e2;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic r, logic [1:0] s, logic sg1, logic sg2,
                                logic [3:0] sp1, logic [3:0] sp2,
                                logic se1, logic se2);
        vec_t v;
        v.rst_n = r;  v.sel = s;   v.g1 = sg1; v.g2 = sg2;
        v.p1    = sp1; v.p2 = sp2; v.e1 = se1; v.e2 = se2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: what each section should read after an edge
    function automatic logic [W-1:0] ref_y(logic r, logic g, logic [1:0] s,
                                           logic [W-1:0] d0, logic [W-1:0] d1,
                                           logic [W-1:0] d2, logic [W-1:0] d3);
        logic [W-1:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        if (!r || g) return '0;
        return d[int'(s)];
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0; b = 1'b0; a = 1'b0; g1 = 1'b1; g2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c1[i] = '0;
            c2[i] = '0;
        end

        // ---------------- directed table ----------------
        // Reset held two edges with everything enabled and ones selected
        vt.push_back(mk(1'b0, 2'b11, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0));
        vt.push_back(mk(1'b0, 2'b11, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 2'b11, 1'b0, 1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1));
        // Strobe disable on section 1
        vt.push_back(mk(1'b1, 2'b00, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0));
        // Walking select, selected input high
        vt.push_back(mk(1'b1, 2'b00, 1'b0, 1'b1, 4'b1000, 4'b1111, 1'b1, 1'b0));
        vt.push_back(mk(1'b1, 2'b01, 1'b0, 1'b1, 4'b0100, 4'b1111, 1'b1, 1'b0));
        vt.push_back(mk(1'b1, 2'b10, 1'b0, 1'b1, 4'b0010, 4'b1111, 1'b1, 1'b0));
        vt.push_back(mk(1'b1, 2'b11, 1'b0, 1'b1, 4'b0001, 4'b1111, 1'b1, 1'b0));
        // Walking select, selected input low, others high
        vt.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 4'b0111, 4'b1000, 1'b0, 1'b1));
        vt.push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 4'b1011, 4'b0100, 1'b0, 1'b1));
        vt.push_back(mk(1'b1, 2'b10, 1'b0, 1'b0, 4'b1101, 4'b0010, 1'b0, 1'b1));
        vt.push_back(mk(1'b1, 2'b11, 1'b0, 1'b0, 4'b1110, 4'b0001, 1'b0, 1'b1));
        // Section independence, then strobes swapped
        vt.push_back(mk(1'b1, 2'b10, 1'b0, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0));
        vt.push_back(mk(1'b1, 2'b10, 1'b1, 1'b0, 4'b0010, 4'b0010, 1'b0, 1'b1));
        // Toggling 1C1 with sel=01
        vt.push_back(mk(1'b1, 2'b01, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0));
        vt.push_back(mk(1'b1, 2'b01, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0));
        vt.push_back(mk(1'b1, 2'b01, 1'b0, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0));
        vt.push_back(mk(1'b1, 2'b01, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0));

        @(negedge clk);
        foreach (vt[k]) begin
            rst_n = vt[k].rst_n;
            {b, a} = vt[k].sel;
            g1 = vt[k].g1;
            g2 = vt[k].g2;
            for (int i = 0; i < 4; i++) begin
                c1[i] = {{(W-1){1'b0}}, vt[k].p1[3-i]};
                c2[i] = {{(W-1){1'b0}}, vt[k].p2[3-i]};
            end
            tick();
            chk($sformatf("vec%0d_y1", k), y1, {{(W-1){1'b0}}, vt[k].e1});
            chk($sformatf("vec%0d_y2", k), y2, {{(W-1){1'b0}}, vt[k].e2});
        end

        // ---------------- latency: output holds until the next edge ----------------
        rst_n = 1'b1; {b, a} = 2'b01; g1 = 1'b0;
        c1[1] = 8'h3C;
        tick();
        chk("lat_load", y1, 8'h3C);
        c1[1] = 8'hC3;
        #2;
        chk("lat_hold", y1, 8'h3C);
        tick();
        chk("lat_next", y1, 8'hC3);

        // ---------------- mid-stream reset on wide data ----------------
        {b, a} = 2'b11; g2 = 1'b0; c2[3] = 8'hA5;
        tick();
        chk("wide_load", y2, 8'hA5);
        rst_n = 1'b0;
        tick();
        chk("wide_rst", y2, 8'h00);
        chk("wide_rst_y1", y1, 8'h00);
        rst_n = 1'b1;
        tick();
        chk("wide_release", y2, 8'hA5);

        // ---------------- randomized against reference ----------------
        for (int n = 0; n < 300; n++) begin
            logic [W-1:0] e1, e2;
            rst_n = ($urandom_range(0, 15) != 0);
            {b, a} = 2'($urandom_range(0, 3));
            g1 = ($urandom_range(0, 3) == 0);
            g2 = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++) begin
                c1[i] = W'($urandom);
                c2[i] = W'($urandom);
            end
            e1 = ref_y(rst_n, g1, {b, a}, c1[0], c1[1], c1[2], c1[3]);
            e2 = ref_y(rst_n, g2, {b, a}, c2[0], c2[1], c2[2], c2[3]);
            tick();
            chk($sformatf("rnd%0d_y1", n), y1, e1);
            chk($sformatf("rnd%0d_y2", n), y2, e2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_sn54ls153
`default_nettype wire

// File: doc/sn54ls153.md
# sn54ls153

Registered dual 4-to-1 data selector/multiplexer modelled on the SN54LS153: two independent sections share one 2-bit select (B:A), and each section has its own active-low strobe. It is a leaf datapath primitive in the session-6 logic library, used wherever a clocked, strobe-gated 4:1 selection is needed. Each section's output is registered on `i_clk` and is cleared by a synchronous active-low reset.

## Interface
- `WIDTH`, default 1: bit width of every data input and of each output.
- `i_clk`  in  1  system clock; all state updates on its rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low; one clock, reset is synchronous and active-low.
- `i_B`  in  1  select MSB, shared by both sections.
- `i_A`  in  1  select LSB, shared by both sections.
- `i_1G`  in  1  section-1 strobe, active-low (0 = enabled).
- `i_2G`  in  1  section-2 strobe, active-low (0 = enabled).
- `i_1C0`..`i_1C3`  in  WIDTH  section-1 data inputs 0..3.
- `i_2C0`..`i_2C3`  in  WIDTH  section-2 data inputs 0..3.
- `o_1Y`  out  WIDTH  section-1 registered output.
- `o_2Y`  out  WIDTH  section-2 registered output.

## Operation
- Select index is {i_B, i_A}: 00→C0, 01→C1, 10→C2, 11→C3. Both sections always use the same index.
- Section n next value:
  - If `i_nG` = 1, the next value is all-zeros, regardless of select and data (datasheet strobe-high forces Y low).
  - If `i_nG` = 0, the next value is `i_nC[{B,A}]`.
- The two sections are fully independent except for the shared select. Strobing one section has no effect on the other.
- An X or Z on the select while a section is enabled is not defined behaviour. Verification treats it as a don't-care, and RTL needs no special handling for it.
- No internal state beyond the two output registers.

## Timing
- Latency: exactly 1 clock. Inputs sampled at rising edge k appear on `o_nY` after edge k and stay stable until edge k+1.
- Reset:
  - `i_rst_n` = 0 at a rising edge forces `o_1Y` = `o_2Y` = 0 after that edge. Reset overrides strobe and data.
  - Reset takes effect only on clock edges. There is no asynchronous path.
- Reset release: the first edge with `i_rst_n` = 1 loads the normal mux result.
- Mid-operation reset: the values in flight are discarded. The outputs read 0 for every reset edge and resume 1 cycle after release.
- Simultaneous select, data and strobe changes before the same edge: the edge captures the combination present at setup time. There is no priority between inputs, other than strobe forcing zero.
- Power-up before the first reset edge: the output value is unspecified.

## Structure
- Shared package `sn54ls153_pkg`:
  - select encoding constants `SEL_C0`=2'b00, `SEL_C1`=2'b01, `SEL_C2`=2'b10, `SEL_C3`=2'b11.
  - strobe constant `STB_ACTIVE`=1'b0.
- One sub-module, `ls153_section`, instantiated twice:
  - Parameters: WIDTH.
  - Ports: clk, rst_n, sel[1:0], g, c0..c3, y.
  - Contents: the combinational strobe-gated 4:1 mux followed by the output register.
- Top level only concatenates {i_B, i_A} and wires the two instances.

## Test plan
- Reset: hold `i_rst_n`=0 with `i_1G`=`i_2G`=0, sel=11, all C inputs=1 for 2 edges → `o_1Y`=`o_2Y`=0. Release → both read 1 one edge later.
- Strobe disable: `i_1G`=1, sel=00, `i_1C0..3`=1111 → `o_1Y`=0 after the edge.
- Walking select on section 1 with `i_1G`=0, one edge per step; inputs listed as {C0,C1,C2,C3}:
  - sel=00 with 1000 → `o_1Y`=1.
  - sel=01 with 0100 → 1.
  - sel=10 with 0010 → 1.
  - sel=11 with 0001 → 1.
  - Repeat each step with only the selected input 0 and the others 1 → 0 each cycle.
- Section independence: `i_1G`=0, `i_2G`=1, sel=10, `i_1C2`=1, `i_2C2`=1 → `o_1Y`=1, `o_2Y`=0. Swap the strobes → `o_1Y`=0, `o_2Y`=1.
- Latency: toggle `i_1C1` each cycle with sel=01, `i_1G`=0 → `o_1Y` follows it delayed by exactly one edge.
- Mid-stream reset plus wide data: WIDTH=8, sel=11, `i_2C3`=8'hA5, `i_2G`=0 → `o_2Y`=8'hA5. Assert reset for one edge → 8'h00. Release → 8'hA5 the next edge.
